rect_fill_packer: RTL and testbench
===================================

# rect_fill_packer

Upstream producer for the screen VRAM write stage. It accepts rectangle-fill commands through a valid/ready handshake. For each command it emits one packed 32-bit `info` word per clock, sweeping the rectangle in raster order. Each word carries x and y coordinates, a 4-bit colour id and a frame-end flag, in the layout the screen stage decodes. Between commands it drives an all-zero word. That word decodes to x=0, which is outside the visible window, so no VRAM write occurs.

## Interface
Parameters:
- `SCREEN_WIDTH`, 10: width of each coordinate field in `info`, and of the command coordinate and size inputs.
- `STEP`, 2: raw-coordinate increment between adjacent pixels. The screen stage drops the coordinate LSB, so a step of 2 gives one distinct pixel per word.

Ports:
- `clk`  in  1: the single clock. All state changes on its rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: block can accept a command.
- `cmd_x0`  in  SCREEN_WIDTH: raw x of the top-left pixel.
- `cmd_y0`  in  SCREEN_WIDTH: raw y of the top-left pixel.
- `cmd_w`  in  SCREEN_WIDTH: pixels per row.
- `cmd_h`  in  SCREEN_WIDTH: number of rows.
- `cmd_color`  in  4: colour id.
- `cmd_last`  in  1: command completes a frame.
- `info`  out  32: packed word to the screen stage.
- `busy`  out  1: a fill is in progress.
- `done`  out  1: one-cycle completion pulse.

## Operation
- `info` packing:
  - x in [2*SCREEN_WIDTH+7 : SCREEN_WIDTH+8], i.e. [27:18].
  - y in [SCREEN_WIDTH+7 : 8], i.e. [17:8].
  - colour in [3:0].
  - bit 31 is the frame-end flag.
  - Bits [30:28] and [7:4] are always 0.
- States:
  - IDLE: `cmd_ready`=1, `busy`=0, `info`=0.
  - FILL: `cmd_ready`=0, `busy`=1.
- Handshake: a command is accepted on a rising edge where `cmd_valid` && `cmd_ready`. At acceptance the block latches x0, y0, w, h, colour and last.
- Zero-size command (w==0 or h==0):
  - No words are emitted and the block stays in IDLE.
  - `done` pulses in the cycle after acceptance.
- Non-zero command: go to FILL and load the first word (x0, y0) into `info` on the accepting edge.
- Advance per cycle in FILL:
  - Column count below w-1: x += STEP.
  - Otherwise: x = x0, y += STEP, column count = 0, row count += 1.
- Arithmetic: all coordinate arithmetic is modulo 2^SCREEN_WIDTH. Overflow truncates and wraps; it is not an error.
- Final word (column count = w-1 and row count = h-1):
  - bit 31 = latched last. Bit 31 is 0 on every other word.
  - `done` is high in the same cycle as this word.
  - The next edge returns to IDLE with `info`=0.
- Inputs are not sampled while the block is not ready; `cmd_*` changes during FILL have no effect.

## Timing
- Reset values: `info`=0, `done`=0, `busy`=0, `cmd_ready`=1, state IDLE, all counters 0.
- Asynchronous `rst` mid-fill aborts the command immediately: `info`=0 without waiting for a clock edge, and no `done` pulse.
- Latency: first word appears 1 cycle after the accepting edge. A command occupies exactly w*h consecutive cycles.
- Back-to-back commands: one bubble cycle minimum, with `info`=0, between the last word of one command and the first word of the next.
- All outputs are registered, except `cmd_ready`, which is decoded from the state register.

## Test plan
- Reset: assert `rst` with no clock. Required: `info`=0x00000000, `cmd_ready`=1, `busy`=0, `done`=0.
- 2x2 fill: x0=200, y0=300, colour=5, last=0.
  - `info` sequence: 0x03212C05, 0x03292C05, 0x03212E05, 0x03292E05, then 0.
  - `done` high with the 4th word only. `busy` high for 4 cycles.
- 1x1 frame end: x0=160, y0=200, colour=0xF, last=1.
  - Single word 0x8280C80F with `done`=1, then 0.
- Zero width: w=0, h=5.
  - No non-zero `info`. `done` pulses the cycle after acceptance. `cmd_ready` stays 1 and `busy` stays 0.
- Wrap: x0=1022, y0=0, w=2, h=1, colour=1.
  - Words 0x0FF80001 then 0x00000001. `done` with the second word.
- Reset mid-fill: 3x3 command with `rst` asserted after 4 words.
  - `info` goes to 0 immediately, `busy`=0, no `done` pulse.
  - A following 1x1 command emits exactly one correct word.

Source files
------------

// File: rtl/rect_fill_packer.sv
// Rectangle-fill command packer: sweeps a w x h rectangle in raster order and
// emits one packed {frame_end, x, y, colour} word per clock to the screen stage.
module rect_fill_packer #(
    parameter int SCREEN_WIDTH = 10,
    parameter int STEP         = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [SCREEN_WIDTH-1:0] cmd_x0,
    input  logic [SCREEN_WIDTH-1:0] cmd_y0,
    input  logic [SCREEN_WIDTH-1:0] cmd_w,
    input  logic [SCREEN_WIDTH-1:0] cmd_h,
    input  logic [3:0]              cmd_color,
    input  logic                    cmd_last,
    output logic [31:0]             info,
    output logic                    busy,
    output logic                    done
);

    localparam int W = SCREEN_WIDTH;
    localparam logic [W-1:0] STEP_W = W'(STEP);

    typedef enum logic {IDLE, FILL} state_t;

    state_t       state_q;
    logic [W-1:0] x0_q, w_q, h_q;
    logic [W-1:0] x_q, y_q, col_q, row_q;
    logic [3:0]   color_q;
    logic         last_q;
    logic [31:0]  info_q;
    logic         busy_q, done_q;

    logic [W-1:0] x_d, y_d, col_d, row_d;
    logic         col_end, row_end, final_d;

    function automatic logic [31:0] pack(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic [3:0] c, input logic f);
        logic [31:0] wd;
        wd             = '0;
        wd[31]         = f;
        wd[2*W+7 -: W] = x;
        wd[W+7 -: W]   = y;
        wd[3:0]        = c;
        return wd;
    endfunction

    // Raster advance: coordinate arithmetic wraps modulo 2^W by truncation.
    always_comb begin
        col_end = (col_q == w_q - 1'b1);
        row_end = (row_q == h_q - 1'b1);
        x_d     = x_q + STEP_W;
        y_d     = y_q;
        col_d   = col_q + 1'b1;
        row_d   = row_q;
        if (col_end) begin
            x_d   = x0_q;
            y_d   = y_q + STEP_W;
            col_d = '0;
            row_d = row_q + 1'b1;
        end
        final_d = (col_d == w_q - 1'b1) && (row_d == h_q - 1'b1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x0_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
            row_q   <= '0;
            color_q <= '0;
            last_q  <= 1'b0;
            info_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    info_q <= '0;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (cmd_valid) begin
                        x0_q    <= cmd_x0;
                        w_q     <= cmd_w;
                        h_q     <= cmd_h;
                        x_q     <= cmd_x0;
                        y_q     <= cmd_y0;
                        col_q   <= '0;
                        row_q   <= '0;
                        color_q <= cmd_color;
                        last_q  <= cmd_last;
                        if (cmd_w == '0 || cmd_h == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= FILL;
                            busy_q  <= 1'b1;
                            done_q  <= (cmd_w == W'(1)) && (cmd_h == W'(1));
                            info_q  <= pack(cmd_x0, cmd_y0, cmd_color,
                                            cmd_last && (cmd_w == W'(1)) && (cmd_h == W'(1)));
                        end
                    end
                end
                FILL: begin
                    if (col_end && row_end) begin
                        state_q <= IDLE;
                        info_q  <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else begin
                        x_q    <= x_d;
                        y_q    <= y_d;
                        col_q  <= col_d;
                        row_q  <= row_d;
                        info_q <= pack(x_d, y_d, color_q, last_q && final_d);
                        done_q <= final_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign info      = info_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_rect_fill_packer.sv
// Directed bench for rect_fill_packer: table of fill commands with expected word
// streams, plus hand-written reset, zero-size and reset-mid-fill sequences.
module tb_rect_fill_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_x0 = '0, cmd_y0 = '0, cmd_w = '0, cmd_h = '0;
    logic [3:0]  cmd_color = '0;
    logic        cmd_last = 1'b0;
    logic [31:0] info;
    logic        busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    rect_fill_packer #(.SCREEN_WIDTH(10), .STEP(2)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_color(cmd_color), .cmd_last(cmd_last),
        .info(info), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  x0, y0, w, h;
        logic [3:0]  color;
        logic        last;
        int          n;
        logic [31:0] exp0, exp1, exp2, exp3;
    } vec_t;

    vec_t vecs[6];

    function automatic vec_t mk(input logic [9:0] x0, input logic [9:0] y0,
                                input logic [9:0] w, input logic [9:0] h,
                                input logic [3:0] c, input logic l, input int n,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic [31:0] e2, input logic [31:0] e3);
        vec_t v;
        v.x0 = x0; v.y0 = y0; v.w = w; v.h = h; v.color = c; v.last = l; v.n = n;
        v.exp0 = e0; v.exp1 = e1; v.exp2 = e2; v.exp3 = e3;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] e;
        @(negedge clk);
        cmd_x0 = v.x0; cmd_y0 = v.y0; cmd_w = v.w; cmd_h = v.h;
        cmd_color = v.color; cmd_last = v.last; cmd_valid = 1'b1;
        check($sformatf("v%0d ready_before", idx), 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        for (int k = 0; k < v.n; k++) begin
            // Scramble inputs during the fill; they must be ignored.
            cmd_valid = (k < v.n - 1);
            cmd_x0 = 10'($urandom); cmd_y0 = 10'($urandom);
            cmd_w = 10'($urandom); cmd_h = 10'($urandom);
            cmd_color = 4'($urandom); cmd_last = 1'($urandom);
            case (k)
                0:       e = v.exp0;
                1:       e = v.exp1;
                2:       e = v.exp2;
                default: e = v.exp3;
            endcase
            check($sformatf("v%0d info[%0d]", idx, k), info, e);
            check($sformatf("v%0d busy[%0d]", idx, k), 32'(busy), 32'd1);
            check($sformatf("v%0d done[%0d]", idx, k), 32'(done), 32'(k == v.n - 1));
            check($sformatf("v%0d ready[%0d]", idx, k), 32'(cmd_ready), 32'd0);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        check($sformatf("v%0d info_after", idx), info, 32'd0);
        check($sformatf("v%0d busy_after", idx), 32'(busy), 32'd0);
        check($sformatf("v%0d done_after", idx), 32'(done), 32'd0);
        check($sformatf("v%0d ready_after", idx), 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        vecs[0] = mk(10'd200, 10'd300, 10'd2, 10'd2, 4'h5, 1'b0, 4,
                     32'h03212C05, 32'h03292C05, 32'h03212E05, 32'h03292E05);
        vecs[1] = mk(10'd160, 10'd200, 10'd1, 10'd1, 4'hF, 1'b1, 1,
                     32'h8280C80F, 32'h0, 32'h0, 32'h0);
        vecs[2] = mk(10'd1022, 10'd0, 10'd2, 10'd1, 4'h1, 1'b0, 2,
                     32'h0FF80001, 32'h00000001, 32'h0, 32'h0);
        vecs[3] = mk(10'd10, 10'd20, 10'd3, 10'd1, 4'h3, 1'b1, 3,
                     32'h00281403, 32'h00301403, 32'h80381403, 32'h0);
        vecs[4] = mk(10'd0, 10'd1020, 10'd1, 10'd3, 4'h2, 1'b0, 3,
                     32'h0003FC02, 32'h0003FE02, 32'h00000002, 32'h0);
        vecs[5] = mk(10'd4, 10'd6, 10'd1, 10'd1, 4'h9, 1'b0, 1,
                     32'h00100609, 32'h0, 32'h0, 32'h0);

        // Reset with no clock edge yet
        #2 rst = 1'b1;
        #1;
        check("rst info", info, 32'd0);
        check("rst ready", 32'(cmd_ready), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        #10 rst = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Zero-width command
        @(negedge clk);
        cmd_x0 = 10'd50; cmd_y0 = 10'd60; cmd_w = 10'd0; cmd_h = 10'd5;
        cmd_color = 4'h7; cmd_last = 1'b1; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("zero done", 32'(done), 32'd1);
        check("zero info", info, 32'd0);
        check("zero ready", 32'(cmd_ready), 32'd1);
        check("zero busy", 32'(busy), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("zero done_after[%0d]", k), 32'(done), 32'd0);
            check($sformatf("zero info_after[%0d]", k), info, 32'd0);
            check($sformatf("zero busy_after[%0d]", k), 32'(busy), 32'd0);
        end

        // Reset mid-fill after four words of a 3x3 command
        @(negedge clk);
        cmd_x0 = 10'd4; cmd_y0 = 10'd6; cmd_w = 10'd3; cmd_h = 10'd3;
        cmd_color = 4'h9; cmd_last = 1'b1; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("mid info[0]", info, 32'h00100609);
        @(posedge clk); #1;
        check("mid info[1]", info, 32'h00180609);
        @(posedge clk); #1;
        check("mid info[2]", info, 32'h00200609);
        @(posedge clk); #1;
        check("mid info[3]", info, 32'h00100809);
        check("mid busy[3]", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid rst info", info, 32'd0);
        check("mid rst busy", 32'(busy), 32'd0);
        check("mid rst done", 32'(done), 32'd0);
        check("mid rst ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check($sformatf("mid post done[%0d]", k), 32'(done), 32'd0);
            check($sformatf("mid post info[%0d]", k), info, 32'd0);
        end
        run_vec(vecs[5], 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
